// File: rtl/tclk_sequencer.sv
// Emulated CPU clock (T) sequencer with power-clear and synchronous-clear strobes.
// Phases are stretched to a minimum length so flip-flop D inputs settle before each T rise.
module tclk_sequencer #(
    parameter int CW        = 16,
    parameter int MIN_PHASE = 16,
    parameter int PC_HOLD   = 64,
    parameter int SC_TCYC   = 4
) (
    input  logic          U,
    input  logic          _RESET,
    input  logic          run,
    input  logic          step_req,
    output logic          step_ack,
    input  logic          clr_req,
    input  logic [CW-1:0] cfg_lo,
    input  logic [CW-1:0] cfg_hi,
    output logic          T,
    output logic          _PCO,
    output logic          _SCO,
    output logic          busy,
    output logic [31:0]   tcount
);

    localparam int PCW  = $clog2(PC_HOLD + 1);
    localparam int CNTW = (CW > PCW) ? CW : PCW;
    localparam int SCW  = $clog2(SC_TCYC + 1);

    localparam logic [CW-1:0]   MIN_C   = CW'(MIN_PHASE);
    localparam logic [CNTW-1:0] HOLD_C  = CNTW'(PC_HOLD);
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [SCW-1:0]  SC_LOAD = SCW'(SC_TCYC);
    localparam logic [SCW-1:0]  SC_ONE  = SCW'(1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_LO, S_HI} state_t;

    state_t          state_reg, state_next;
    logic [CNTW-1:0] cnt_reg, cnt_next;
    logic [SCW-1:0]  sc_left_reg, sc_left_next;
    logic            sc_pend_reg, sc_pend_next;
    logic            step_pend_reg, step_pend_next;
    logic            t_reg, t_next;
    logic            pco_reg, pco_next;
    logic            sco_reg, sco_next;
    logic            ack_reg, ack_next;
    logic [31:0]     tcount_reg, tcount_next;

    logic [CW-1:0]   lo_eff, hi_eff;
    logic [CNTW-1:0] lo_load, hi_load, cnt_dec;
    logic            enter_lo, step_acc, sc_active;

    // Counters hold (length - 1) so a phase lasts exactly its effective length.
    assign lo_eff  = (cfg_lo < MIN_C) ? MIN_C : cfg_lo;
    assign hi_eff  = (cfg_hi < MIN_C) ? MIN_C : cfg_hi;
    assign lo_load = CNTW'(lo_eff) - CNT_ONE;
    assign hi_load = CNTW'(hi_eff) - CNT_ONE;
    assign cnt_dec = cnt_reg - CNT_ONE;
    assign sc_active = (sc_left_reg != '0) || sc_pend_reg;

    always_ff @(posedge U or negedge _RESET) begin
        if (!_RESET) begin
            state_reg     <= S_INIT;
            cnt_reg       <= HOLD_C;
            sc_left_reg   <= '0;
            sc_pend_reg   <= 1'b0;
            step_pend_reg <= 1'b0;
            t_reg         <= 1'b0;
            pco_reg       <= 1'b0;
            sco_reg       <= 1'b1;
            ack_reg       <= 1'b0;
            tcount_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sc_left_reg   <= sc_left_next;
            sc_pend_reg   <= sc_pend_next;
            step_pend_reg <= step_pend_next;
            t_reg         <= t_next;
            pco_reg       <= pco_next;
            sco_reg       <= sco_next;
            ack_reg       <= ack_next;
            tcount_reg    <= tcount_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        sc_left_next   = sc_left_reg;
        step_pend_next = step_pend_reg;
        t_next         = t_reg;
        pco_next       = pco_reg;
        sco_next       = sco_reg;
        ack_next       = 1'b0;
        tcount_next    = tcount_reg;
        enter_lo       = 1'b0;
        step_acc       = 1'b0;

        case (state_reg)
            S_INIT: begin
                if (cnt_reg <= CNT_ONE) begin
                    state_next = S_IDLE;
                    pco_next   = 1'b1;
                end else begin
                    cnt_next = cnt_dec;
                end
            end
            S_IDLE: begin
                step_acc = step_req && !run && !step_pend_reg;
                if (step_acc) step_pend_next = 1'b1;
                enter_lo = run || sc_active || step_acc;
            end
            S_LO: begin
                if (cnt_reg == '0) begin
                    state_next  = S_HI;
                    cnt_next    = hi_load;
                    t_next      = 1'b1;
                    tcount_next = tcount_reg + 32'd1;
                    if (sc_left_reg != '0) sc_left_next = sc_left_reg - SC_ONE;
                end else begin
                    cnt_next = cnt_dec;
                end
            end
            S_HI: begin
                if (cnt_reg == '0) begin
                    t_next = 1'b0;
                    if (step_pend_reg) begin
                        ack_next       = 1'b1;
                        step_pend_next = 1'b0;
                    end
                    if (run || sc_active) begin
                        enter_lo = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                        sco_next   = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_dec;
                end
            end
            default: state_next = S_INIT;
        endcase

        // _SCO only moves at LO entry so D sees it for the whole low phase.
        if (enter_lo) begin
            state_next = S_LO;
            cnt_next   = lo_load;
            if (sc_pend_reg) begin
                sc_left_next = SC_LOAD;
                sco_next     = 1'b0;
            end else if (sc_left_reg == '0) begin
                sco_next = 1'b1;
            end
        end

        sc_pend_next = (sc_pend_reg && !enter_lo) || (clr_req && (state_reg != S_INIT));
    end

    assign T        = t_reg;
    assign _PCO     = pco_reg;
    assign _SCO     = sco_reg;
    assign step_ack = ack_reg;
    assign tcount   = tcount_reg;
    assign busy     = (state_reg == S_LO) || (state_reg == S_HI);

endmodule

// File: tb/tb_tclk_sequencer.sv
// Bench for tclk_sequencer: timestamp-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tclk_sequencer;

    localparam int CW        = 16;
    localparam int MIN_PHASE = 2;
    localparam int PC_HOLD   = 8;
    localparam int SC_TCYC   = 3;

    logic          U = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          step_req = 1'b0;
    logic          clr_req = 1'b0;
    logic [CW-1:0] cfg_lo = 16'd5;
    logic [CW-1:0] cfg_hi = 16'd3;
    logic          step_ack, T, pco, sco, busy;
    logic [31:0]   tcount;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    tclk_sequencer #(
        .CW(CW), .MIN_PHASE(MIN_PHASE), .PC_HOLD(PC_HOLD), .SC_TCYC(SC_TCYC)
    ) dut (
        .U(U), ._RESET(rst_n), .run(run), .step_req(step_req), .step_ack(step_ack),
        .clr_req(clr_req), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .T(T), ._PCO(pco),
        ._SCO(sco), .busy(busy), .tcount(tcount)
    );

    always #5 U = ~U;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: absolute edge timestamps for T rise and HI end.
    int          m_e = 0;
    int          m_mode = 0;      // 0 power-clear hold, 1 idle, 2 cycling
    int          m_rise = 0;
    int          m_end = 0;
    int          m_scn = 0;
    bit          m_scp = 0;
    bit          m_stp = 0;
    bit          m_pco = 0;
    bit          m_sco = 1;
    bit          m_ack = 0;
    logic [31:0] m_tc = '0;

    function automatic int eff(input logic [CW-1:0] c);
        return (int'(c) < MIN_PHASE) ? MIN_PHASE : int'(c);
    endfunction

    task automatic m_begin(input int at);
        m_mode = 2;
        m_rise = at + eff(cfg_lo);
        m_end  = 32'h7fffffff;
        if (m_scp) begin
            m_scn = SC_TCYC;
            m_scp = 0;
            m_sco = 0;
        end else if (m_scn == 0) begin
            m_sco = 1;
        end
    endtask

    always @(posedge U or negedge rst_n) begin
        if (!rst_n) begin
            m_e = 0; m_mode = 0; m_rise = 0; m_end = 0; m_scn = 0; m_scp = 0;
            m_stp = 0; m_pco = 0; m_sco = 1; m_ack = 0; m_tc = '0;
        end else begin
            bit clr_ok;
            clr_ok = clr_req && (m_mode != 0);
            m_e++;
            m_ack = 0;
            if (m_mode == 0) begin
                if (m_e == PC_HOLD) begin
                    m_mode = 1;
                    m_pco  = 1;
                end
            end else if (m_mode == 1) begin
                bit st;
                st = step_req && !run && !m_stp;
                if (st) m_stp = 1;
                if (run || m_scp || m_scn > 0 || st) m_begin(m_e);
            end else if (m_e == m_rise) begin
                m_tc = m_tc + 32'd1;
                if (m_scn > 0) m_scn--;
                m_end = m_e + eff(cfg_hi);
            end else if (m_e == m_end) begin
                if (m_stp) begin
                    m_ack = 1;
                    m_stp = 0;
                end
                if (run || m_scn > 0 || m_scp) m_begin(m_e);
                else begin
                    m_mode = 1;
                    m_sco  = 1;
                end
            end
            if (clr_ok) m_scp = 1;
        end
    end

    always @(negedge U) begin
        if (cmp_en) begin
            logic exp_t;
            exp_t = (m_mode == 2) && (m_e >= m_rise) && (m_e < m_end);
            chk("T", T, exp_t);
            chk("PCO", pco, m_pco);
            chk("SCO", sco, m_sco);
            chk("busy", busy, (m_mode == 2));
            chk("step_ack", step_ack, m_ack);
            chk("tcount", tcount, m_tc);
        end
    end

    task automatic run_len(input logic v, output int n);
        n = 0;
        while (T === v && n < 100) begin
            n++;
            @(negedge U);
        end
    endtask

    task automatic skip(input logic v);
        int n;
        run_len(v, n);
        chk("wait_T_bound", (n < 100), 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            @(negedge U);
            k++;
        end
        chk("idle_bound", (k < 200), 1);
    endtask

    task automatic init_window(input string tag);
        int lows = 0;
        int acks = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge U);
            if (!pco) lows++;
            if (step_ack) acks++;
            if (T) acks += 100;
            step_req = (i == 2);
            clr_req  = (i == 3);
        end
        step_req = 0;
        clr_req  = 0;
        chk({tag, "_pco_low_cycles"}, lows, PC_HOLD);
        chk({tag, "_no_ack_no_T"}, acks, 0);
    endtask

    initial begin
        int n, hi_n, lo_n, acks, rises;
        logic [31:0] tc0;
        logic prev_t;

        repeat (3) @(negedge U);
        cmp_en = 1'b1;
        @(negedge U);
        chk("rst_T", T, 0);
        chk("rst_PCO", pco, 0);
        chk("rst_SCO", sco, 1);
        chk("rst_tcount", tcount, 0);

        @(posedge U);
        #2 rst_n = 1'b1;
        init_window("init");

        // Free run 5/3: 80 edges from LO entry hold 10 rises and 30 high cycles.
        run = 1;
        hi_n = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge U);
            if (T) hi_n++;
        end
        chk("run_tcount10", tcount, 10);
        chk("model_tc10", m_tc, 10);
        chk("run_high_cycles", hi_n, 30);

        skip(1); skip(0);
        run_len(1, hi_n);
        run_len(0, lo_n);
        chk("period_hi3", hi_n, 3);
        chk("period_lo5", lo_n, 5);

        cfg_lo = 7;
        skip(1);
        run_len(0, lo_n);
        chk("lo_after_change7", lo_n, 7);

        cfg_lo = 0;
        cfg_hi = 1;
        skip(1); skip(0);
        run_len(1, hi_n);
        run_len(0, lo_n);
        chk("clamp_hi2", hi_n, 2);
        chk("clamp_lo2", lo_n, 2);

        // Single step, with a second request while busy that must be dropped.
        run = 0;
        wait_idle();
        cfg_lo = 4;
        cfg_hi = 4;
        @(negedge U);
        tc0 = tcount;
        acks = 0;
        rises = 0;
        prev_t = T;
        for (int i = 0; i < 30; i++) begin
            step_req = (i == 0) || (i == 4);
            @(negedge U);
            if (step_ack) acks++;
            if (T && !prev_t) rises++;
            prev_t = T;
        end
        step_req = 0;
        chk("step_tcount", tcount, tc0 + 32'd1);
        chk("step_acks", acks, 1);
        chk("step_rises", rises, 1);

        // Clear from idle: three automatic cycles of 4+4 with _SCO low throughout.
        tc0 = tcount;
        lo_n = 0;
        clr_req = 1;
        @(negedge U);
        clr_req = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge U);
            if (!sco) lo_n++;
        end
        chk("clr_tcount", tcount, tc0 + 32'd3);
        chk("clr_sco_low", lo_n, 24);
        chk("clr_sco_end", sco, 1);
        chk("clr_busy_end", busy, 0);

        for (int i = 0; i < 2000; i++) begin
            @(negedge U);
            if ($urandom_range(0, 39) == 0) run = ~run;
            step_req = ($urandom_range(0, 7) == 0);
            clr_req  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0) cfg_lo = CW'($urandom_range(0, 6));
            if ($urandom_range(0, 19) == 0) cfg_hi = CW'($urandom_range(0, 6));
        end
        step_req = 0;
        clr_req  = 0;

        // Asynchronous reset landing in the middle of a high phase.
        run = 1;
        cfg_lo = 5;
        cfg_hi = 3;
        @(negedge U);
        skip(1); skip(0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_T", T, 0);
        chk("async_PCO", pco, 0);
        chk("async_tcount", tcount, 0);
        chk("async_busy", busy, 0);
        repeat (3) @(negedge U);
        @(posedge U);
        #2 rst_n = 1'b1;
        init_window("reinit");
        repeat (40) @(negedge U);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
